hit_acc: RTL
============

HIT_ACC -- requirements
Module: hit_acc

Interface
REQ-001 The block SHALL expose parameter LU_W, default 4, meaning hit bits per lookup beat.
REQ-002 The block SHALL expose parameter CAND_W, default 16, meaning accumulator/candidate width.
REQ-003 The block SHALL expose parameter LEN_W, default 8, meaning beat-count width.
REQ-004 clk_i  input  1  single clock; all state rises on posedge.
REQ-005 rst_i  input  1  asynchronous, active-low reset.
REQ-006 start_i  input  1  begin a new accumulation set; honoured in IDLE only.
REQ-007 len_i  input  LEN_W  number of beats in the set; sampled with start_i.
REQ-008 abort_i  input  1  synchronous abort of the current set.
REQ-009 hit_valid_i  input  1  hit_i carries a valid beat.
REQ-010 hit_i  input  LU_W  per-beat hit vector.
REQ-011 hit_ready_o  output  1  block accepts a beat this cycle.
REQ-012 cand_valid_o  output  1  candidate_o holds a final result.
REQ-013 cand_ready_i  input  1  consumer takes the result.
REQ-014 candidate_o  output  CAND_W  accumulated hit count.
REQ-015 busy_o  output  1  high in any state other than IDLE.
REQ-016 ovf_o  output  1  sticky overflow flag for the current set.

Function
REQ-017 The FSM SHALL have three states: IDLE, ACC and DONE.
REQ-018 IDLE SHALL go to ACC on start_i with len_i!=0, and to DONE on start_i with len_i==0; both transitions clear the accumulator and ovf_o.
REQ-019 In ACC, hit_ready_o SHALL be 1; it SHALL be 0 in IDLE and DONE.
REQ-020 A beat SHALL be accepted on any cycle with hit_valid_i && hit_ready_o; the beat adds popcount(hit_i), zero-extended to CAND_W.
REQ-021 A remaining-beat counter SHALL load len_i on start and decrement once per accepted beat; the last accepted beat moves the FSM to DONE.
REQ-022 cand_valid_o SHALL rise the cycle after the last beat is accepted (1-cycle latency), with candidate_o already including that beat.
REQ-023 In DONE, candidate_o SHALL be stable and cand_valid_o held until cand_valid_o && cand_ready_i; the FSM then goes to IDLE and cand_valid_o drops on the next cycle.
REQ-024 candidate_o SHALL retain its last value in IDLE until the next start.
REQ-025 start_i SHALL be ignored in ACC and DONE.
REQ-026 abort_i SHALL move any state to IDLE on the next edge, clear the accumulator, counter and ovf_o, and drop cand_valid_o; any beat offered in that cycle is discarded.
REQ-027 If abort_i and start_i are high together in IDLE, abort_i SHALL win and no set starts.
REQ-028 Elaboration SHALL fail unless CAND_W >= clog2(LU_W+1).

Reset
REQ-029 While rst_i is low, the state SHALL be IDLE and candidate_o, the counter, ovf_o, cand_valid_o, hit_ready_o and busy_o SHALL all be 0, asynchronously and regardless of the clock.
REQ-030 Reset released mid-set SHALL leave no residue; the next start begins a clean set.

Configuration
REQ-031 With macro HIT_ACC_SAT_EN defined, an addition exceeding 2^CAND_W-1 SHALL clamp candidate_o at all-ones and set ovf_o until the next start, abort or reset.
REQ-032 Without HIT_ACC_SAT_EN, accumulation SHALL wrap modulo 2^CAND_W and ovf_o SHALL be tied to 0.

Structure
REQ-033 Default widths (LU_BUS_SZ, CANDIDATE_SZ), LEN_W and the FSM state encodings SHALL live in the shared def.v header.
REQ-034 Popcount SHALL be a separate combinational sub-module, hit_popcnt, parametrised by LU_W.
REQ-035 The top level SHALL hold the FSM, counter, accumulator and overflow logic.

Verification
REQ-036 start, len=3, beats 4'b1111/4'b0101/4'b0001, cand_ready=1 -> candidate_o=7; cand_valid_o high for exactly 1 cycle, 1 cycle after the third beat.
REQ-037 start, len=0 -> DONE next cycle, candidate_o=0, no beat accepted.
REQ-038 len=4 with hit_valid_i toggled 1,0,1,0,...; cand_ready low for 5 cycles after done -> only valid beats counted; candidate_o stable and valid held for all 5 cycles.
REQ-039 CAND_W=3, len=3, three beats of 4'b1111: with HIT_ACC_SAT_EN -> candidate_o=7, ovf_o=1; without it -> candidate_o=4 (12 mod 8), ovf_o=0.
REQ-040 abort_i after the 2nd beat of len=5 -> IDLE, candidate_o=0; the next set with len=1 and 4'b0011 -> 2. start+abort in the same IDLE cycle -> stays IDLE.
REQ-041 rst_i low mid-ACC, asserted between clock edges -> all outputs 0 immediately; after release, a fresh set gives the correct count.

Source files
------------

// File: rtl/hit_acc_pkg.sv
// Shared defaults and FSM encoding for the hit accumulator.
package hit_acc_pkg;

  localparam int LU_BUS_SZ    = 4;
  localparam int CANDIDATE_SZ = 16;
  localparam int LEN_SZ       = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/hit_acc_popcnt.sv
// hit_popcnt: combinational population count of one lookup beat.
module hit_popcnt #(
  parameter int LU_W = 4
) (
  input  logic [LU_W-1:0]              hit,
  output logic [$clog2(LU_W + 1)-1:0]  cnt
);

  localparam int CW = $clog2(LU_W + 1);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < LU_W; i++) begin
      cnt = cnt + CW'(hit[i]);
    end
  end

endmodule

// File: rtl/hit_acc.sv
// Hit accumulator: sums popcounts over a set of len_i beats and hands the total off.
// Define HIT_ACC_SAT_EN to saturate at all-ones with a sticky ovf_o; otherwise it wraps.
module hit_acc
  import hit_acc_pkg::*;
#(
  parameter int LU_W   = LU_BUS_SZ,
  parameter int CAND_W = CANDIDATE_SZ,
  parameter int LEN_W  = LEN_SZ
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              abort_i,
  input  logic              hit_valid_i,
  input  logic [LU_W-1:0]   hit_i,
  output logic              hit_ready_o,
  output logic              cand_valid_o,
  input  logic              cand_ready_i,
  output logic [CAND_W-1:0] candidate_o,
  output logic              busy_o,
  output logic              ovf_o
);

  localparam int PC_W = $clog2(LU_W + 1);

  if (CAND_W < PC_W) begin : g_width_check
    $error("hit_acc: CAND_W cannot hold the popcount of LU_W bits");
  end

  state_t            state;
  logic [CAND_W-1:0] acc;
  logic [CAND_W-1:0] acc_next;
  logic [LEN_W-1:0]  remain;
  logic [PC_W-1:0]   pc;
  logic              accept;

  hit_popcnt #(.LU_W(LU_W)) u_popcnt (
    .hit (hit_i),
    .cnt (pc)
  );

  assign accept = hit_valid_i && (state == ST_ACC);

`ifdef HIT_ACC_SAT_EN
  logic [CAND_W:0] sum;
  logic            ovf;

  // The extra carry bit tells us the add ran past all-ones.
  assign sum      = {1'b0, acc} + (CAND_W + 1)'(pc);
  assign acc_next = sum[CAND_W] ? '1 : sum[CAND_W-1:0];
  assign ovf_o    = ovf;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ovf <= 1'b0;
    end else if (abort_i || (state == ST_IDLE && start_i)) begin
      ovf <= 1'b0;
    end else if (accept && sum[CAND_W]) begin
      ovf <= 1'b1;
    end
  end
`else
  assign acc_next = acc + CAND_W'(pc);
  assign ovf_o    = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= ST_IDLE;
      acc    <= '0;
      remain <= '0;
    end else if (abort_i) begin
      state  <= ST_IDLE;
      acc    <= '0;
      remain <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            acc    <= '0;
            remain <= len_i;
            state  <= (len_i == '0) ? ST_DONE : ST_ACC;
          end
        end
        ST_ACC: begin
          if (accept) begin
            acc    <= acc_next;
            remain <= remain - LEN_W'(1);
            if (remain == LEN_W'(1)) begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (cand_ready_i) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Status outputs decode straight from the state flop, so they carry no input paths.
  assign hit_ready_o  = (state == ST_ACC);
  assign cand_valid_o = (state == ST_DONE);
  assign busy_o       = (state != ST_IDLE);
  assign candidate_o  = acc;

endmodule
